muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 50 +++++
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared definitions for the RV32M multiply/divide unit:
//   - op_t    : RV32M funct3 encodings (MUL..REMU)
//   - state_t : FSM state encoding (IDLE, CALC, DONE)
//   - ITER    : number of shift-add / restoring-divide iterations
//   - helpers : per-op operand signedness and divide/multiply class
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int unsigned ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(input op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // MUL is treated as signed x signed; its low word is identical either way.
    function automatic logic rs1_is_signed(input op_t op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic rs2_is_signed(input op_t op);
        return (op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit with a fixed 33-cycle latency.
//   Operands are converted to magnitudes at start, a shared 64-bit shift
//   register and 33-bit adder/subtractor run 32 shift-add or restoring-divide
//   steps, and the sign is re-applied in a final post-processing cycle.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   request strobe, sampled only in IDLE
//   op[2:0]     in   RV32M funct3
//   rs1_data    in   first operand
//   rs2_data    in   second operand
//   rd_addr_in  in   destination register index
//   busy        out  operation in flight (CALC or DONE)
//   done        out  one-cycle result strobe
//   rd_we       out  register-file write enable (done and rd_addr != 0)
//   rd_addr     out  register-file write index, held between results
//   rd_wdata    out  register-file write data, held between results
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr_in,
    output logic            busy,
    output logic            done,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata
);

    localparam logic [5:0] ITER_CNT = 6'(ITER);

    state_t              state;
    logic [5:0]          cnt;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   acc_next;
    logic [XLEN-1:0]     opb;
    op_t                 op_q;
    logic                neg_q;
    logic [4:0]          dst_q;

    op_t                 op_in;
    logic                s1;
    logic                s2;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                neg_in;

    logic [XLEN:0]       add_a;
    logic [XLEN:0]       add_b;
    logic                add_cin;
    logic [XLEN:0]       sum;

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     remv;
    logic [XLEN-1:0]     result;

    assign op_in = op_t'(op);

    // Sign pre-processing: magnitudes plus the sign to re-apply at the end.
    always_comb begin
        s1     = rs1_is_signed(op_in) & rs1_data[XLEN-1];
        s2     = rs2_is_signed(op_in) & rs2_data[XLEN-1];
        mag_a  = s1 ? (-rs1_data) : rs1_data;
        mag_b  = s2 ? (-rs2_data) : rs2_data;
        neg_in = s1 ^ s2;
        if (op_is_div(op_in)) begin
            if (op_is_rem(op_in)) begin
                // Remainder follows the dividend; with a zero divisor the
                // magnitude is |rs1|, so this also restores rs1 exactly.
                neg_in = s1;
            end else begin
                // A zero divisor must leave the all-ones quotient unnegated.
                neg_in = (s1 ^ s2) & (|rs2_data);
            end
        end
    end

    // Shared adder. Multiply: acc_hi + multiplicand. Divide: the shifted
    // partial remainder minus the divisor (two's complement, carry-in 1).
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (op_is_div(op_q)) begin
            add_a   = acc[2*XLEN-1:XLEN-1];
            add_b   = ~{1'b0, opb};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc[2*XLEN-1:XLEN]};
            add_b   = {1'b0, opb};
        end
    end

    assign sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};

    always_comb begin
        acc_next = acc;
        if (op_is_div(op_q)) begin
            // sum[XLEN] is the borrow: set means the divisor did not fit.
            if (!sum[XLEN]) begin
                acc_next = {sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            // Multiplier sits in the low half and is consumed LSB first.
            if (acc[0]) begin
                acc_next = {sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {add_a, acc[XLEN-1:1]};
            end
        end
    end

    // Sign post-processing and result selection.
    always_comb begin
        prod   = neg_q ? (-acc) : acc;
        quo    = neg_q ? (-acc[XLEN-1:0]) : acc[XLEN-1:0];
        remv   = neg_q ? (-acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        result = '0;
        case (op_q)
            OP_MUL:                       result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              result = quo;
            OP_REM, OP_REMU:              result = remv;
            default:                      result = '0;
        endcase
    end

    // Edge 0 latches, edges 1..32 iterate, edge 33 applies the sign and
    // presents the result, edge 34 returns to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            dst_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_we    <= 1'b0;
            rd_addr  <= '0;
            rd_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q  <= op_in;
                        dst_q <= rd_addr_in;
                        neg_q <= neg_in;
                        opb   <= mag_b;
                        acc   <= {{XLEN{1'b0}}, mag_a};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt != ITER_CNT) begin
                        acc <= acc_next;
                        cnt <= cnt + 6'd1;
                    end else begin
                        rd_wdata <= result;
                        rd_addr  <= dst_q;
                        done     <= 1'b1;
                        rd_we    <= |dst_q;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    rd_we <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
